// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for immediate generation: format encodings and legal XLEN values.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_R     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_I     = 3'd5,
    IMM_ISTAR = 3'd6,
    IMM_Z     = 3'd7
  } imm_sel_e;

  localparam int XLEN_RV32 = 32;
  localparam int XLEN_RV64 = 64;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational RISC-V immediate extractor: instruction word + format select -> XLEN immediate.
module imm_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Opcode bits never contribute to any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_sel_e'(imm_sel))
      IMM_R:     imm = '0;
      IMM_I:     imm = XLEN'($signed(inst[31:20]));
      IMM_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      IMM_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      IMM_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
      IMM_ISTAR: imm = (XLEN == XLEN_RV64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      IMM_Z:     imm = XLEN'(inst[19:15]);
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry output FIFO carrying immediate, tag and illegal flag.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .inst    (in_inst),
    .imm_sel (in_imm_sel),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]  imm_mem_q [2];
  logic [XLEN-1:0]  imm_mem_d [2];
  logic [TAG_W-1:0] tag_mem_q [2];
  logic [TAG_W-1:0] tag_mem_d [2];
  logic [1:0]       ill_mem_q, ill_mem_d;
  logic             push, pop;

  // Both handshakes depend only on registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    imm_mem_d = imm_mem_q;
    tag_mem_d = tag_mem_q;
    ill_mem_d = ill_mem_q;
    if (push) begin
      imm_mem_d[wr_ptr_q] = ext_imm;
      tag_mem_d[wr_ptr_q] = in_tag;
      ill_mem_d[wr_ptr_q] = ext_illegal;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    imm_mem_q <= imm_mem_d;
    tag_mem_q <= tag_mem_d;
    ill_mem_q <= ill_mem_d;
  end

  // Storage is not cleared; outputs are masked to zero whenever the buffer is empty.
  assign out_imm     = out_valid ? imm_mem_q[rd_ptr_q] : '0;
  assign out_tag     = out_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign out_illegal = out_valid && ill_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven by shared stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_sel;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_imm_sel(in_imm_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] inst;
    logic [63:0] e32;
    logic [63:0] e64;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_tag(input logic [31:0] tag);
    in_valid   = 1'b1;
    in_imm_sel = 3'd5;
    in_inst    = 32'h00100093;
    in_tag     = tag;
  endtask

  logic [31:0] q[$];
  bit exp_push, exp_pop;

  initial begin
    in_valid = 1'b0; in_inst = '0; in_imm_sel = '0; in_tag = '0; out_ready = 1'b0;

    vecs[0]  = '{3'd5, 32'hFFF00093, 64'hFFFFFFFF,         64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{3'd3, 32'h800002B7, 64'h80000000,         64'hFFFFFFFF80000000};
    vecs[2]  = '{3'd6, 32'h03F51513, 64'h1F,               64'h3F};
    vecs[3]  = '{3'd2, 32'hFE000EE3, 64'hFFFFFFFC,         64'hFFFFFFFFFFFFFFFC};
    vecs[4]  = '{3'd4, 32'h0040006F, 64'h4,                64'h4};
    vecs[5]  = '{3'd0, 32'hFFFFFFFF, 64'h0,                64'h0};
    vecs[6]  = '{3'd1, 32'hFE512C23, 64'hFFFFFFF8,         64'hFFFFFFFFFFFFFFF8};
    vecs[7]  = '{3'd7, 32'h000FD073, 64'h1F,               64'h1F};
    vecs[8]  = '{3'd7, 32'h800F8073, 64'h1F,               64'h1F};
    vecs[9]  = '{3'd3, 32'h12345037, 64'h12345000,         64'h12345000};
    vecs[10] = '{3'd5, 32'h7FF00013, 64'h7FF,              64'h7FF};
    vecs[11] = '{3'd4, 32'hFFDFF06F, 64'hFFFFFFFC,         64'hFFFFFFFFFFFFFFFC};
    vecs[12] = '{3'd6, 32'h01F51513, 64'h1F,               64'h1F};

    // Reset state
    do_reset();
    chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready32},  64'd1);
    chk("rst_out_imm",   {32'b0, out_imm32},   64'd0);
    chk("rst_out_tag",   {32'b0, out_tag32},   64'd0);
    chk("rst_illegal",   {63'b0, out_illegal32}, 64'd0);
    chk("rst_out_imm64", out_imm64,            64'd0);

    // Streamed vectors: one push per cycle, each visible one cycle after acceptance
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 13; i++) begin
      in_valid   = 1'b1;
      in_imm_sel = vecs[i].sel;
      in_inst    = vecs[i].inst;
      in_tag     = 32'd100 + i;
      tick();
      chk($sformatf("vec%0d_valid", i),   {63'b0, out_valid32}, 64'd1);
      chk($sformatf("vec%0d_imm32", i),   {32'b0, out_imm32},   vecs[i].e32);
      chk($sformatf("vec%0d_imm64", i),   out_imm64,            vecs[i].e64);
      chk($sformatf("vec%0d_tag", i),     {32'b0, out_tag32},   64'd100 + i);
      chk($sformatf("vec%0d_illegal", i), {63'b0, out_illegal32}, 64'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'b0, out_valid32}, 64'd0);
    chk("drain_imm",   {32'b0, out_imm32},   64'd0);

    // Backpressure: three back-to-back pushes with out_ready low
    out_ready = 1'b0;
    push_tag(32'd1);
    tick();
    chk("bp_ready_after1", {63'b0, in_ready32}, 64'd1);
    push_tag(32'd2);
    tick();
    chk("bp_ready_after2", {63'b0, in_ready32}, 64'd0);
    push_tag(32'd3);
    tick();
    chk("bp_head_hold", {32'b0, out_tag32}, 64'd1);
    chk("bp_imm_hold",  {32'b0, out_imm32}, 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_no_comb_path", {63'b0, in_ready32}, 64'd0);
    tick();
    chk("bp_pop1_tag",  {32'b0, out_tag32},  64'd2);
    chk("bp_pop1_ready", {63'b0, in_ready32}, 64'd1);
    tick();
    chk("bp_pop2_tag",  {32'b0, out_tag32},  64'd3);
    in_valid = 1'b0;
    tick();
    chk("bp_empty_valid", {63'b0, out_valid32}, 64'd0);
    chk("bp_empty_tag",   {32'b0, out_tag32},   64'd0);

    // Random push/pop around count=1 against a queue reference
    q.delete();
    push_tag(32'hA000_0000);
    out_ready = 1'b0;
    tick();
    q.push_back(32'hA000_0000);
    for (int unsigned c = 0; c < 20; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_tag    = 32'hA000_0001 + c;
      exp_push  = in_valid && (q.size() < 2);
      exp_pop   = (q.size() != 0) && out_ready;
      tick();
      if (exp_pop) void'(q.pop_front());
      if (exp_push) q.push_back(32'hA000_0001 + c);
      chk($sformatf("rnd%0d_valid", c), {63'b0, out_valid32}, {63'b0, q.size() != 0});
      chk($sformatf("rnd%0d_ready", c), {63'b0, in_ready32},  {63'b0, q.size() < 2});
      if (q.size() != 0)
        chk($sformatf("rnd%0d_tag", c), {32'b0, out_tag32}, {32'b0, q[0]});
    end

    // Reset while full discards both entries
    out_ready = 1'b0;
    push_tag(32'd7);
    tick();
    tick();
    chk("full_before_rst", {63'b0, in_ready32}, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rstfull_valid", {63'b0, out_valid32}, 64'd0);
    chk("rstfull_ready", {63'b0, in_ready32},  64'd1);
    chk("rstfull_imm",   {32'b0, out_imm32},   64'd0);
    chk("rstfull_imm64", out_imm64,            64'd0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
